// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the RAM port arbiter: owner encodings, FSM state
// encodings, the IO region predicate and the address/word type macros.
// No ports (package).

`define ADDR_TP(w) logic [(w)-1:0]
`define WORD_TP logic [31:0]

package mem_port_arbiter_pkg;

   // Owner encodings, also driven to the engine on eng_owner.
   localparam logic [1:0] OWN_IC = 2'd0;
   localparam logic [1:0] OWN_LD = 2'd1;
   localparam logic [1:0] OWN_ST = 2'd2;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FLUSH = 2'd2
   } arb_state_e;

   // Address bits [17:16] == 2'b11 select the memory-mapped IO (UART) region.
   function automatic logic is_io_region(input logic [1:0] addr_hi);
      return (addr_hi == 2'b11);
   endfunction

endpackage

// File: rtl/mem_grant_sel.sv
// mem_grant_sel
// Combinational priority selector. Normal order is st > ld > ic; once the
// age counter has reached STARVE_LIM a pending icache fill wins instead.
// Ports:
//   ic_valid/ld_valid/st_valid : raw requests
//   ic_elig/ld_elig/st_elig    : eligibility masks
//   age                        : consecutive data grants seen by a waiting ic
//   grant                      : one-hot {st, ld, ic}, all zero when nothing to grant

module mem_grant_sel #(
   parameter int AGE_W      = 3,
   parameter int STARVE_LIM = 4
) (
   input  logic             ic_valid,
   input  logic             ld_valid,
   input  logic             st_valid,
   input  logic             ic_elig,
   input  logic             ld_elig,
   input  logic             st_elig,
   input  logic [AGE_W-1:0] age,
   output logic [2:0]       grant
);

   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

   logic ic_req_s;
   logic ld_req_s;
   logic st_req_s;

   // Priority pick with the starvation override for the icache.
   always_comb begin
      ic_req_s = ic_valid & ic_elig;
      ld_req_s = ld_valid & ld_elig;
      st_req_s = st_valid & st_elig;
      grant    = 3'b000;
      if (ic_req_s && (age == AGE_LIM)) begin
         grant = 3'b001;
      end else if (st_req_s) begin
         grant = 3'b100;
      end else if (ld_req_s) begin
         grant = 3'b010;
      end else if (ic_req_s) begin
         grant = 3'b001;
      end else begin
         grant = 3'b000;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the byte-serial RAM engine among icache fill (ic), SLB load (ld)
// and ROB committed store (st). One transaction is outstanding at a time;
// completions are routed back as one-cycle done pulses. Rollback squashes
// ic/ld transactions, stores to the UART region wait while its buffer is full.
// Ports:
//   clk, rst (async, active high), rdy (global freeze), rb (rollback)
//   io_buffer_full            : UART TX buffer full
//   ic_valid/ic_addr/ic_done  : icache fill request and completion
//   ld_*                      : load request, completion, data and ROB tag
//   st_*                      : store request and completion
//   eng_start/rw/addr/len/wdata/owner : launch interface to the engine
//   eng_done/eng_rdata        : engine completion and read data

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int ROB_IDX_W  = 4,
   parameter int LINE_BYTES = 16,
   parameter int STARVE_LIM = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 rb,
   input  logic                 io_buffer_full,
   input  logic                 ic_valid,
   input  logic [ADDR_W-1:0]    ic_addr,
   output logic                 ic_done,
   input  logic                 ld_valid,
   input  logic [ADDR_W-1:0]    ld_addr,
   input  logic [2:0]           ld_len,
   input  logic [ROB_IDX_W-1:0] ld_src,
   output logic                 ld_done,
   output logic [31:0]          ld_data,
   output logic [ROB_IDX_W-1:0] ld_done_src,
   input  logic                 st_valid,
   input  logic [ADDR_W-1:0]    st_addr,
   input  logic [2:0]           st_len,
   input  logic [31:0]          st_data,
   output logic                 st_done,
   output logic                 eng_start,
   output logic                 eng_rw,
   output logic [ADDR_W-1:0]    eng_addr,
   output logic [4:0]           eng_len,
   output logic [31:0]          eng_wdata,
   output logic [1:0]           eng_owner,
   input  logic                 eng_done,
   input  logic [31:0]          eng_rdata
);

   localparam int               AGE_W    = $clog2(STARVE_LIM + 1);
   localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(STARVE_LIM);
   localparam logic [4:0]       LINE_LEN = 5'(LINE_BYTES);

   arb_state_e           state_r;
   arb_state_e           state_nxt_s;
   logic [AGE_W-1:0]     age_r;
   logic [ROB_IDX_W-1:0] ld_src_r;
   logic [2:0]           grant_s;
   logic                 grant_any_s;
   logic                 fin_s;
   logic                 kill_s;
   logic                 st_elig_s;
   logic [1:0]           grant_own_s;
   `ADDR_TP(ADDR_W)      grant_addr_s;
   logic [4:0]           grant_len_s;
   `WORD_TP              grant_wdata_s;

   // A requester whose done pulse is high right now still shows its old valid,
   // so it is masked out for that cycle; UART stores wait on a full buffer.
   always_comb begin
      st_elig_s = ~st_done & ~(is_io_region(st_addr[17:16]) & io_buffer_full);
   end

   mem_grant_sel #(
      .AGE_W      (AGE_W),
      .STARVE_LIM (STARVE_LIM)
   ) u_grant_sel (
      .ic_valid (ic_valid),
      .ld_valid (ld_valid),
      .st_valid (st_valid),
      .ic_elig  (~ic_done),
      .ld_elig  (~ld_done),
      .st_elig  (st_elig_s),
      .age      (age_r),
      .grant    (grant_s)
   );

   // Request fields of the selected requester, latched on grant.
   always_comb begin
      grant_own_s   = OWN_IC;
      grant_addr_s  = ic_addr;
      grant_len_s   = LINE_LEN;
      grant_wdata_s = 32'h0000_0000;
      case (grant_s)
         3'b100: begin
            grant_own_s   = OWN_ST;
            grant_addr_s  = st_addr;
            grant_len_s   = {2'b00, st_len};
            grant_wdata_s = st_data;
         end
         3'b010: begin
            grant_own_s   = OWN_LD;
            grant_addr_s  = ld_addr;
            grant_len_s   = {2'b00, ld_len};
            grant_wdata_s = 32'h0000_0000;
         end
         default: begin
            grant_own_s   = OWN_IC;
            grant_addr_s  = ic_addr;
            grant_len_s   = LINE_LEN;
            grant_wdata_s = 32'h0000_0000;
         end
      endcase
   end

   // Next-state logic: grant from IDLE, completion or squash from BUSY,
   // drain from FLUSH. Stores are never squashed.
   always_comb begin
      state_nxt_s = state_r;
      grant_any_s = 1'b0;
      fin_s       = 1'b0;
      kill_s      = rb & (eng_owner != OWN_ST);
      case (state_r)
         ST_IDLE: begin
            if (!rb && (grant_s != 3'b000)) begin
               state_nxt_s = ST_BUSY;
               grant_any_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (eng_done) begin
               state_nxt_s = ST_IDLE;
               fin_s       = ~kill_s;
            end else if (kill_s) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_FLUSH: begin
            if (eng_done) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else if (rdy) begin
         state_r <= state_nxt_s;
      end
   end

   // Launch pulse and latched request fields toward the engine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_start <= 1'b0;
         eng_rw    <= 1'b0;
         eng_addr  <= {ADDR_W{1'b0}};
         eng_len   <= 5'd0;
         eng_wdata <= 32'h0000_0000;
         eng_owner <= OWN_IC;
         ld_src_r  <= {ROB_IDX_W{1'b0}};
      end else if (rdy) begin
         eng_start <= grant_any_s;
         if (grant_any_s) begin
            eng_rw    <= grant_s[2];
            eng_addr  <= grant_addr_s;
            eng_len   <= grant_len_s;
            eng_wdata <= grant_wdata_s;
            eng_owner <= grant_own_s;
            if (grant_s[1]) begin
               ld_src_r <= ld_src;
            end
         end
      end
   end

   // Starvation age: counts data grants while the icache waits, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_r <= {AGE_W{1'b0}};
      end else if (rdy && grant_any_s) begin
         if (grant_s[0]) begin
            age_r <= {AGE_W{1'b0}};
         end else if (ic_valid && (age_r != AGE_LIM)) begin
            age_r <= age_r + AGE_W'(1);
         end
      end
   end

   // Completion pulses routed to the owner, plus load result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ic_done     <= 1'b0;
         ld_done     <= 1'b0;
         st_done     <= 1'b0;
         ld_data     <= 32'h0000_0000;
         ld_done_src <= {ROB_IDX_W{1'b0}};
      end else if (rdy) begin
         ic_done <= fin_s & (eng_owner == OWN_IC);
         ld_done <= fin_s & (eng_owner == OWN_LD);
         st_done <= fin_s & (eng_owner == OWN_ST);
         if (fin_s && (eng_owner == OWN_LD)) begin
            ld_data     <= eng_rdata;
            ld_done_src <= ld_src_r;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a transaction-level reference
// model, a per-cycle compare process and hand-computed literal expectations.

module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int ROB_IDX_W  = 4;
   localparam int LINE_BYTES = 16;
   localparam int STARVE_LIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        rb = 1'b0;
   logic        io_buffer_full = 1'b0;
   logic        ic_valid = 1'b0;
   logic [31:0] ic_addr = 32'h0;
   logic        ic_done;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = 32'h0;
   logic [2:0]  ld_len = 3'd0;
   logic [3:0]  ld_src = 4'd0;
   logic        ld_done;
   logic [31:0] ld_data;
   logic [3:0]  ld_done_src;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = 32'h0;
   logic [2:0]  st_len = 3'd0;
   logic [31:0] st_data = 32'h0;
   logic        st_done;
   logic        eng_start;
   logic        eng_rw;
   logic [31:0] eng_addr;
   logic [4:0]  eng_len;
   logic [31:0] eng_wdata;
   logic [1:0]  eng_owner;
   logic        eng_done;
   logic [31:0] eng_rdata = 32'h0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .ROB_IDX_W(ROB_IDX_W), .LINE_BYTES(LINE_BYTES), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .io_buffer_full(io_buffer_full),
      .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_src(ld_src),
      .ld_done(ld_done), .ld_data(ld_data), .ld_done_src(ld_done_src),
      .st_valid(st_valid), .st_addr(st_addr), .st_len(st_len), .st_data(st_data),
      .st_done(st_done), .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr),
      .eng_len(eng_len), .eng_wdata(eng_wdata), .eng_owner(eng_owner),
      .eng_done(eng_done), .eng_rdata(eng_rdata)
   );

   // Memory engine stand-in: finishes 'lat' cycles after the start pulse, frozen by rdy.
   int lat = 3;
   int eng_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) eng_cnt <= 0;
      else if (rdy) begin
         if (eng_start) eng_cnt <= lat;
         else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
      end
   end
   assign eng_done = (eng_cnt == 1);

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: one outstanding transaction (owner, or -1 when free).
   int          m_owner = -1;
   bit          m_squash = 1'b0;
   int          m_age = 0;
   logic [3:0]  m_src = 4'd0;
   logic        e_ic_done = 1'b0, e_ld_done = 1'b0, e_st_done = 1'b0, e_start = 1'b0, e_rw = 1'b0;
   logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_ld_data = 32'h0;
   logic [4:0]  e_len = 5'd0;
   logic [1:0]  e_owner = 2'd0;
   logic [3:0]  e_ld_src = 4'd0;

   always @(posedge clk or posedge rst) begin : model_p
      int g;
      bit ok_ic, ok_ld, ok_st, kill, n_ic, n_ld, n_st, n_start;
      if (rst) begin
         m_owner = -1; m_squash = 1'b0; m_age = 0; m_src = 4'd0;
         e_ic_done = 1'b0; e_ld_done = 1'b0; e_st_done = 1'b0; e_start = 1'b0; e_rw = 1'b0;
         e_addr = 32'h0; e_wdata = 32'h0; e_ld_data = 32'h0; e_len = 5'd0; e_owner = 2'd0; e_ld_src = 4'd0;
      end else if (rdy) begin
         n_ic = 1'b0; n_ld = 1'b0; n_st = 1'b0; n_start = 1'b0;
         if (m_owner < 0) begin
            ok_ic = ic_valid && !e_ic_done;
            ok_ld = ld_valid && !e_ld_done;
            ok_st = st_valid && !e_st_done && !(st_addr[17:16] == 2'b11 && io_buffer_full);
            g = -1;
            if (!rb) begin
               if (m_age == STARVE_LIM && ok_ic) g = 0;
               else if (ok_st) g = 2;
               else if (ok_ld) g = 1;
               else if (ok_ic) g = 0;
            end
            if (g >= 0) begin
               n_start = 1'b1; m_owner = g; m_squash = 1'b0; e_owner = 2'(g);
               case (g)
                  0: begin e_addr = ic_addr; e_len = 5'(LINE_BYTES); e_rw = 1'b0; e_wdata = 32'h0; end
                  1: begin e_addr = ld_addr; e_len = {2'b00, ld_len}; e_rw = 1'b0; e_wdata = 32'h0; m_src = ld_src; end
                  default: begin e_addr = st_addr; e_len = {2'b00, st_len}; e_rw = 1'b1; e_wdata = st_data; end
               endcase
               if (g == 0) m_age = 0;
               else if (ic_valid && m_age < STARVE_LIM) m_age = m_age + 1;
            end
         end else begin
            kill = rb && (m_owner != 2);
            if (eng_done) begin
               if (!m_squash && !kill) begin
                  case (m_owner)
                     0: n_ic = 1'b1;
                     1: begin n_ld = 1'b1; e_ld_data = eng_rdata; e_ld_src = m_src; end
                     default: n_st = 1'b1;
                  endcase
               end
               m_owner = -1; m_squash = 1'b0;
            end else if (kill) begin
               m_squash = 1'b1;
            end
         end
         e_ic_done = n_ic; e_ld_done = n_ld; e_st_done = n_st; e_start = n_start;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Event recorder fed from DUT outputs (observed values, not expectations).
   logic [1:0] own_q[$];
   int start_cnt = 0, ic_n = 0, ld_n = 0, st_n = 0;
   int last_start_cyc = 0, last_engdone_cyc = 0, last_lddone_cyc = 0;
   logic [31:0] seen_ld_data = 32'h0;
   logic [3:0]  seen_ld_src = 4'd0;

   // Per-cycle compare against the model, sampled on the falling edge.
   always @(negedge clk) begin
      chk("eng_start", 32'(eng_start), 32'(e_start));
      chk("eng_rw", 32'(eng_rw), 32'(e_rw));
      chk("eng_addr", eng_addr, e_addr);
      chk("eng_len", 32'(eng_len), 32'(e_len));
      chk("eng_wdata", eng_wdata, e_wdata);
      chk("eng_owner", 32'(eng_owner), 32'(e_owner));
      chk("ic_done", 32'(ic_done), 32'(e_ic_done));
      chk("ld_done", 32'(ld_done), 32'(e_ld_done));
      chk("st_done", 32'(st_done), 32'(e_st_done));
      chk("ld_data", ld_data, e_ld_data);
      chk("ld_done_src", 32'(ld_done_src), 32'(e_ld_src));
      if (eng_start) begin own_q.push_back(eng_owner); start_cnt++; last_start_cyc = cyc; end
      if (eng_done) last_engdone_cyc = cyc;
      if (ic_done) ic_n++;
      if (st_done) st_n++;
      if (ld_done) begin ld_n++; last_lddone_cyc = cyc; seen_ld_data = ld_data; seen_ld_src = ld_done_src; end
   end

   bit keep_ic = 1'b0, keep_ld = 1'b0, keep_st = 1'b0;

   // One clock; requesters drop valid the cycle after their done pulse.
   task automatic cycle();
      logic d_ic, d_ld, d_st;
      d_ic = ic_done; d_ld = ld_done; d_st = st_done;
      @(posedge clk); #1;
      if (d_ic && !keep_ic) ic_valid = 1'b0;
      if (d_ld && !keep_ld) ld_valid = 1'b0;
      if (d_st && !keep_st) st_valid = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_starts(input string name, input int n);
      for (int i = 0; i < 200 && start_cnt < n; i++) cycle();
      chk(name, 32'(start_cnt), 32'(n));
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; rb = 1'b0; io_buffer_full = 1'b0; lat = 3;
      ic_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
      keep_ic = 1'b0; keep_ld = 1'b0; keep_st = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      own_q.delete(); start_cnt = 0; ic_n = 0; ld_n = 0; st_n = 0;
   endtask

   initial begin
      int c0;
      int exp_seq[10];

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("reset_eng_owner", 32'(eng_owner), 32'd0);
      chk("reset_eng_start", 32'(eng_start), 32'd0);

      // 1: all three at once -> st, ld, ic, each done one cycle.
      do_reset();
      ic_valid = 1'b1; ic_addr = 32'h0000_0100;
      ld_valid = 1'b1; ld_addr = 32'h0000_0204; ld_len = 3'd4; ld_src = 4'd3;
      st_valid = 1'b1; st_addr = 32'h0000_0308; st_len = 3'd2; st_data = 32'h0000_A5A5;
      wait_starts("t1_starts", 3);
      for (int i = 0; i < 30 && ic_n == 0; i++) cycle();
      run(3);
      chk("t1_own0", 32'(own_q[0]), 32'd2);
      chk("t1_own1", 32'(own_q[1]), 32'd1);
      chk("t1_own2", 32'(own_q[2]), 32'd0);
      chk("t1_ic_pulse", 32'(ic_n), 32'd1);
      chk("t1_ld_pulse", 32'(ld_n), 32'd1);
      chk("t1_st_pulse", 32'(st_n), 32'd1);

      // 2: continuous data traffic with ic waiting -> ic after exactly 4 data grants, twice.
      do_reset();
      keep_ic = 1'b1; keep_ld = 1'b1; keep_st = 1'b1;
      ic_valid = 1'b1; ld_valid = 1'b1; st_valid = 1'b1;
      wait_starts("t2_starts", 10);
      exp_seq = '{2, 1, 2, 1, 0, 2, 1, 2, 1, 0};
      for (int i = 0; i < 10; i++) chk($sformatf("t2_own%0d", i), 32'(own_q[i]), 32'(exp_seq[i]));
      keep_ic = 1'b0; keep_ld = 1'b0; keep_st = 1'b0;
      ic_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
      run(10);

      // 3: UART store held off by full buffer; granted the cycle after it drains.
      do_reset();
      io_buffer_full = 1'b1;
      st_valid = 1'b1; st_addr = 32'h0003_0000; st_len = 3'd4; st_data = 32'h1122_3344;
      ld_valid = 1'b1; ld_addr = 32'h0000_0040; ld_len = 3'd1; ld_src = 4'd7;
      wait_starts("t3_first", 1);
      run(15);
      chk("t3_store_held", 32'(start_cnt), 32'd1);
      chk("t3_own0", 32'(own_q[0]), 32'd1);
      io_buffer_full = 1'b0;
      c0 = cyc;
      wait_starts("t3_second", 2);
      chk("t3_own1", 32'(own_q[1]), 32'd2);
      chk("t3_latency", 32'(last_start_cyc - c0), 32'd1);
      run(8);

      // 4: load squashed by rollback, then rb in IDLE delays the next grant by one cycle.
      do_reset();
      lat = 5;
      ld_valid = 1'b1; ld_addr = 32'h0000_0080; ld_len = 3'd2; ld_src = 4'd9;
      wait_starts("t4_start", 1);
      cycle();
      rb = 1'b1; ld_valid = 1'b0;
      cycle();
      rb = 1'b0;
      run(10);
      chk("t4_no_ld_done", 32'(ld_n), 32'd0);
      lat = 3;
      ic_valid = 1'b1; ic_addr = 32'h0000_1000; rb = 1'b1;
      c0 = cyc;
      cycle();
      rb = 1'b0;
      wait_starts("t4_next", 2);
      chk("t4_rb_idle_delay", 32'(last_start_cyc - c0), 32'd2);
      for (int i = 0; i < 20 && ic_n == 0; i++) cycle();
      chk("t4_own1", 32'(own_q[1]), 32'd0);
      chk("t4_ic_done", 32'(ic_n), 32'd1);

      // 5: a store in flight is never squashed.
      do_reset();
      lat = 4;
      st_valid = 1'b1; st_addr = 32'h0000_0500; st_len = 3'd4; st_data = 32'hCAFE_F00D;
      wait_starts("t5_start", 1);
      rb = 1'b1;
      cycle();
      rb = 1'b0;
      run(10);
      chk("t5_st_done", 32'(st_n), 32'd1);

      // 6: load result and tag arrive one cycle after eng_done.
      do_reset();
      eng_rdata = 32'hDEAD_BEEF;
      ld_valid = 1'b1; ld_addr = 32'h0000_1234; ld_len = 3'd4; ld_src = 4'd5;
      for (int i = 0; i < 30 && ld_n == 0; i++) cycle();
      chk("t6_ld_done", 32'(ld_n), 32'd1);
      chk("t6_ld_data", seen_ld_data, 32'hDEAD_BEEF);
      chk("t6_ld_src", 32'(seen_ld_src), 32'd5);
      chk("t6_done_lag", 32'(last_lddone_cyc - last_engdone_cyc), 32'd1);
      chk("t6_total", 32'(last_lddone_cyc - last_start_cyc), 32'd4);
      run(3);

      // 7: rdy low for 3 cycles mid-transaction delays completion by exactly 3.
      do_reset();
      ld_valid = 1'b1; ld_addr = 32'h0000_2000; ld_len = 3'd1; ld_src = 4'd2;
      wait_starts("t7_start", 1);
      rdy = 1'b0;
      run(3);
      chk("t7_frozen_owner", 32'(eng_owner), 32'd1);
      chk("t7_frozen_addr", eng_addr, 32'h0000_2000);
      rdy = 1'b1;
      for (int i = 0; i < 30 && ld_n == 0; i++) cycle();
      chk("t7_ld_done", 32'(ld_n), 32'd1);
      chk("t7_total", 32'(last_lddone_cyc - last_start_cyc), 32'd7);
      run(3);

      // 8: asynchronous reset mid-transaction clears outputs at once; completion lost.
      do_reset();
      lat = 6;
      ld_valid = 1'b1; ld_addr = 32'h0000_3000; ld_len = 3'd4; ld_src = 4'd4;
      wait_starts("t8_start", 1);
      cycle();
      chk("t8_pre_owner", 32'(eng_owner), 32'd1);
      chk("t8_pre_addr", eng_addr, 32'h0000_3000);
      #2 rst = 1'b1;
      #1;
      chk("t8_rst_owner", 32'(eng_owner), 32'd0);
      chk("t8_rst_addr", eng_addr, 32'h0);
      chk("t8_rst_len", 32'(eng_len), 32'd0);
      ld_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      run(10);
      chk("t8_lost", 32'(ld_n), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
